reg_write_arbiter: RTL

Shares the single write port of the 32x32 register file (`banco_reg`) among several writeback sources. It arbitrates round-robin, accepts one write per cycle with a valid/ready handshake and drives the register file's `A3`/`wd3`/`we3` from a registered output stage. A lock mechanism lets one source perform back-to-back writes, for example a multi-register load, bounded by a burst limit. It sits between the writeback sources and the register file's write port.

---
 rtl/reg_arb_pkg.sv | 12 +
 rtl/reg_write_arbiter_if.sv | 32 +++
 rtl/rr_picker.sv | 30 +++
 rtl/reg_write_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package reg_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    // Burst counter width; covers LOCK_MAX up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side handshake bundle: per-requester valid/lock/addr/data plus the ready vector.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = REG_AW,
    parameter int unsigned DW   = REG_DW
) ();

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_lock;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_data;
    logic [NREQ-1:0]         req_ready;

    modport master (
        output req_valid,
        output req_lock,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_lock,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_gnt_idx
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_idx     = '0;
        w_found   = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IW'((32'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register file write port, with bounded lock bursts
// and a registered A3/wd3/we3 output stage.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned AW       = REG_AW,
    parameter int unsigned DW       = REG_DW,
    parameter int unsigned LOCK_MAX = 4,
    parameter int unsigned IW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_write_arbiter_if.slave   bus,
    output logic [AW-1:0]        A3,
    output logic [DW-1:0]        wd3,
    output logic                 we3,
    output logic [IW-1:0]        lock_owner,
    output logic                 locked
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     w_ptr_nxt;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     w_owner_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [AW-1:0]     r_a3;
    logic [DW-1:0]     r_wd3;
    logic              r_we3;

    logic [NREQ-1:0]   w_pick_gnt;
    logic [IW-1:0]     w_pick_idx;
    logic [NREQ-1:0]   w_ready;
    logic              w_xfer;
    logic [IW-1:0]     w_g;
    logic              w_lock_g;
    logic [AW-1:0]     w_addr_g;
    logic [DW-1:0]     w_data_g;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_pick_gnt),
        .o_gnt_idx (w_pick_idx)
    );

    // Ready is forced low while reset is held so no transfer is acknowledged then.
    always_comb begin
        w_ready = '0;
        if (!rst) begin
            if (r_state == ARB_IDLE) begin
                w_ready = w_pick_gnt;
            end else begin
                w_ready[r_owner] = bus.req_valid[r_owner];
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign w_xfer        = |w_ready;
    assign w_g           = (r_state == ARB_IDLE) ? w_pick_idx : r_owner;
    assign w_lock_g      = bus.req_lock[w_g];
    assign w_addr_g      = bus.req_addr[w_g];
    assign w_data_g      = bus.req_data[w_g];
    assign w_cnt_inc     = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_xfer) begin
                    w_ptr_nxt = w_g;
                    if (w_lock_g && (LOCK_MAX > 1)) begin
                        w_state_nxt = ARB_LOCKED;
                        w_owner_nxt = w_g;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                // ptr already equals the owner, leaving it lowest priority on exit.
                if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (!w_lock_g || (w_cnt_inc == CNT_W'(LOCK_MAX))) begin
                        w_state_nxt = ARB_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= IW'(NREQ - 1);
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // x0 writes are accepted on the handshake but never enable the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a3  <= '0;
            r_wd3 <= '0;
            r_we3 <= 1'b0;
        end else if (w_xfer) begin
            r_a3  <= w_addr_g;
            r_wd3 <= w_data_g;
            r_we3 <= (w_addr_g != '0);
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign A3         = r_a3;
    assign wd3        = r_wd3;
    assign we3        = r_we3;
    assign lock_owner = r_owner;
    assign locked     = (r_state == ARB_LOCKED);

endmodule
